// File: rtl/pipe_spawn_pkg.sv
// Shared constants and the LFSR step function for the pipe spawn generator.
package pipe_spawn_pkg;

   localparam logic [15:0] LFSR_SEED   = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS   = 16'hB400;
   localparam int          Y_MASK_BITS = 7;
   localparam int          Y_WIDTH     = 10;
   localparam logic [Y_WIDTH-1:0] Y_MIN = 10'd20;

   // One Galois step of x^16+x^14+x^13+x^11+1; a nonzero state never reaches zero.
   function automatic logic [15:0] lfsr_step(input logic [15:0] state);
      return (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/pipe_spawn_gen_clock_divider.sv
// Enable-gated counter that toggles `out` every PERIOD enabled cycles.
// `wrap` flags the enabled cycle whose clock edge performs the toggle,
// so the parent can register an edge-aligned event without a delay stage.
module clock_divider #(
   parameter int PERIOD = 90
) (
   input  logic clk,
   input  logic en,
   input  logic reset,
   output logic out,
   output logic wrap
);

   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   assign wrap = en && (cnt == CNT_LAST);

   // Counter and square-wave register; reset wins over enable and any pending toggle.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         cnt <= '0;
         out <= 1'b0;
      end else if (wrap) begin
         cnt <= '0;
         out <= ~out;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_spawn_gen.sv
// Pipe spawn timing and gap-height source.
// Divides the frame clock into tick_out, pulses spawn on each rising toggle,
// and exposes a bounded pseudo-random gap Y from a 16-bit Galois LFSR.
// Build option: PIPE_SPAWN_GEN_FREERUN_RNG_EN makes the LFSR advance every
// clock (outside reset) instead of only on spawn edges.
module pipe_spawn_gen
   import pipe_spawn_pkg::*;
#(
   parameter int PERIOD = 90
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   output logic               tick_out,
   output logic               spawn,
   output logic [Y_WIDTH-1:0] rand_y
);

   logic        wrap;
   logic        spawn_next;
   logic        lfsr_adv;
   logic [15:0] lfsr;

   clock_divider #(
      .PERIOD(PERIOD)
   ) u_clock_divider (
      .clk  (clk),
      .en   (en),
      .reset(reset),
      .out  (tick_out),
      .wrap (wrap)
   );

   // A toggle from a low tick_out is the rising edge that launches a pipe.
   assign spawn_next = wrap & ~tick_out;

`ifdef PIPE_SPAWN_GEN_FREERUN_RNG_EN
   assign lfsr_adv = 1'b1;
`else
   assign lfsr_adv = spawn_next;
`endif

   // Spawn pulse register, high for exactly the cycle tick_out first reads 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         spawn <= 1'b0;
      end else begin
         spawn <= spawn_next;
      end
   end

   // LFSR register; advancing on the spawn edge makes the new gap visible with spawn.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else if (lfsr_adv) begin
         lfsr <= lfsr_step(lfsr);
      end
   end

   // Low bits offset into the playfield: 20..147 keeps gap top + 70 on screen.
   assign rand_y = Y_MIN + {{(Y_WIDTH - Y_MASK_BITS){1'b0}}, lfsr[Y_MASK_BITS-1:0]};

endmodule

// File: tb/tb_pipe_spawn_gen.sv
// Self-checking bench for pipe_spawn_gen: three instances (PERIOD 90, 3, 1)
// share clock and reset, each with its own enable, checked against a
// counting model of enabled cycles and a precomputed LFSR value table.
module tb_pipe_spawn_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] en;
   logic [2:0] tick;
   logic [2:0] spw;
   logic [9:0] ry [3];

   int checks = 0;
   int errors = 0;

   // Model state
   int          cyc;
   int          en_cnt  [3];
   bit          last_en [3];
   logic [15:0] seq     [16384];

   always #5 clk = ~clk;

   pipe_spawn_gen #(.PERIOD(90)) u_dut90 (
      .clk(clk), .reset(reset), .en(en[0]),
      .tick_out(tick[0]), .spawn(spw[0]), .rand_y(ry[0]));
   pipe_spawn_gen #(.PERIOD(3)) u_dut3 (
      .clk(clk), .reset(reset), .en(en[1]),
      .tick_out(tick[1]), .spawn(spw[1]), .rand_y(ry[1]));
   pipe_spawn_gen #(.PERIOD(1)) u_dut1 (
      .clk(clk), .reset(reset), .en(en[2]),
      .tick_out(tick[2]), .spawn(spw[2]), .rand_y(ry[2]));

   function automatic int period_of(input int d);
      case (d)
         0:       return 90;
         1:       return 3;
         default: return 1;
      endcase
   endfunction

   // tick_out is high during odd half-periods of the enabled-cycle count.
   function automatic logic exp_tick(input int d);
      return logic'(((en_cnt[d] / period_of(d)) % 2) == 1);
   endfunction

   // spawn follows an enabled edge landing on an odd multiple of PERIOD.
   function automatic logic exp_spawn(input int d);
      int p;
      p = period_of(d);
      return logic'(last_en[d] && en_cnt[d] > 0 && (en_cnt[d] % p) == 0 &&
                    ((en_cnt[d] / p) % 2) == 1);
   endfunction

   function automatic logic [9:0] exp_y(input int d);
      int steps;
`ifdef PIPE_SPAWN_GEN_FREERUN_RNG_EN
      steps = cyc;
`else
      steps = (en_cnt[d] / period_of(d) + 1) / 2;
`endif
      return 10'd20 + {3'b000, seq[steps][6:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
         if (en[d]) en_cnt[d]++;
         last_en[d] = en[d];
      end
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      cyc = 0;
      for (int d = 0; d < 3; d++) begin
         en_cnt[d]  = 0;
         last_en[d] = 1'b0;
      end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      en = 3'b111;
      do_reset(2);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (tick[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick d%0d: got %b want 0", d, tick[d]);
         end
         checks++;
         if (spw[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_spawn d%0d: got %b want 0", d, spw[d]);
         end
         checks++;
         if (ry[d] !== 10'd117) begin
            errors++;
            $display("FAIL reset_rand_y d%0d: got %0d want 117", d, ry[d]);
         end
      end
   endtask

   task automatic test_period90();
      int rises[$];
      int falls[$];
      int spawns[$];
      logic prev;
      en = 3'b111;
      do_reset(2);
      prev = tick[0];
      for (int k = 1; k <= 400; k++) begin
         step();
         if (tick[0] && !prev) rises.push_back(k);
         if (!tick[0] && prev) falls.push_back(k);
         if (spw[0]) spawns.push_back(k);
         prev = tick[0];
         checks++;
         if (tick[0] !== exp_tick(0) || spw[0] !== exp_spawn(0)) begin
            errors++;
            $display("FAIL p90_cycle k=%0d: got tick=%b spawn=%b want tick=%b spawn=%b",
                     k, tick[0], spw[0], exp_tick(0), exp_spawn(0));
         end
      end
      checks++;
      if (rises.size() != 2 || rises[0] != 90 || rises[1] != 270) begin
         errors++;
         $display("FAIL p90_rises: got %p want 90,270", rises);
      end
      checks++;
      if (falls.size() != 2 || falls[0] != 180 || falls[1] != 360) begin
         errors++;
         $display("FAIL p90_falls: got %p want 180,360", falls);
      end
      checks++;
      if (spawns.size() != 2 || spawns[0] != 90 || spawns[1] != 270) begin
         errors++;
         $display("FAIL p90_spawns: got %p want 90,270", spawns);
      end
   endtask

   task automatic test_rand_p3();
      int seen;
      int model_spawns;
      int guard;
      en = 3'b111;
      do_reset(2);
      seen = 0;
      model_spawns = 0;
      guard = 0;
      while (model_spawns < 1000 && guard < 7000) begin
         step();
         guard++;
         if (exp_spawn(1)) model_spawns++;
         if (spw[1] === 1'b1) seen++;
         checks++;
         if (spw[1] !== exp_spawn(1) || ry[1] !== exp_y(1)) begin
            errors++;
            $display("FAIL p3_rng k=%0d: got spawn=%b y=%0d want spawn=%b y=%0d",
                     guard, spw[1], ry[1], exp_spawn(1), exp_y(1));
         end
         checks++;
         if (ry[1] < 10'd20 || ry[1] > 10'd147) begin
            errors++;
            $display("FAIL p3_range k=%0d: got %0d want 20..147", guard, ry[1]);
         end
`ifndef PIPE_SPAWN_GEN_FREERUN_RNG_EN
         if (guard == 2) begin
            checks++;
            if (ry[1] !== 10'd117) begin
               errors++;
               $display("FAIL p3_pre_spawn: got %0d want 117", ry[1]);
            end
         end
         if (guard == 3) begin
            checks++;
            if (ry[1] !== 10'd132 || spw[1] !== 1'b1) begin
               errors++;
               $display("FAIL p3_first_spawn: got y=%0d spawn=%b want y=132 spawn=1",
                        ry[1], spw[1]);
            end
         end
`endif
      end
      checks++;
      if (seen != 1000) begin
         errors++;
         $display("FAIL p3_spawn_count: got %0d want 1000", seen);
      end
   endtask

   task automatic test_pause();
      int first;
      first = -1;
      en = 3'b111;
      do_reset(2);
      for (int k = 1; k <= 200; k++) begin
         en[0] = !(k > 50 && k <= 90);
         step();
         if (spw[0] === 1'b1 && first < 0) first = k;
         checks++;
         if (tick[0] !== exp_tick(0) || spw[0] !== exp_spawn(0)) begin
            errors++;
            $display("FAIL pause_cycle k=%0d: got tick=%b spawn=%b want tick=%b spawn=%b",
                     k, tick[0], spw[0], exp_tick(0), exp_spawn(0));
         end
         if (!en[0]) begin
            checks++;
            if (spw[0] !== 1'b0) begin
               errors++;
               $display("FAIL pause_quiet k=%0d: got spawn=%b want 0", k, spw[0]);
            end
         end
      end
      en[0] = 1'b1;
      checks++;
      if (first != 130) begin
         errors++;
         $display("FAIL pause_first_spawn: got %0d want 130", first);
      end
   endtask

   task automatic test_period1();
      en = 3'b111;
      do_reset(2);
      for (int k = 1; k <= 20; k++) begin
         step();
         checks++;
         if (tick[2] !== logic'(k % 2) || spw[2] !== logic'(k % 2)) begin
            errors++;
            $display("FAIL p1_cycle k=%0d: got tick=%b spawn=%b want tick=%b spawn=%b",
                     k, tick[2], spw[2], logic'(k % 2), logic'(k % 2));
         end
      end
   endtask

   task automatic test_reset_midcount();
      int first;
      first = -1;
      en = 3'b111;
      do_reset(2);
      repeat (50) step();
      do_reset(1);
      checks++;
      if (tick[0] !== 1'b0 || ry[0] !== 10'd117) begin
         errors++;
         $display("FAIL midreset_state: got tick=%b y=%0d want tick=0 y=117", tick[0], ry[0]);
      end
      for (int k = 1; k <= 95; k++) begin
         step();
         if (spw[0] === 1'b1 && first < 0) first = k;
      end
      checks++;
      if (first != 90) begin
         errors++;
         $display("FAIL midreset_first_spawn: got %0d want 90", first);
      end
   endtask

   task automatic test_en_low();
      en = 3'b000;
      do_reset(2);
      for (int k = 1; k <= 20; k++) begin
         step();
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (spw[d] !== 1'b0 || tick[d] !== 1'b0 || ry[d] !== exp_y(d)) begin
               errors++;
               $display("FAIL en_low k=%0d d%0d: got tick=%b spawn=%b y=%0d want tick=0 spawn=0 y=%0d",
                        k, d, tick[d], spw[d], ry[d], exp_y(d));
            end
         end
         if (k == 1) begin
            checks++;
`ifdef PIPE_SPAWN_GEN_FREERUN_RNG_EN
            if (ry[1] !== 10'd132) begin
               errors++;
               $display("FAIL freerun_first: got %0d want 132", ry[1]);
            end
`else
            if (ry[1] !== 10'd117) begin
               errors++;
               $display("FAIL hold_first: got %0d want 117", ry[1]);
            end
`endif
         end
      end
   endtask

   task automatic test_random_en();
      en = 3'b111;
      do_reset(2);
      for (int k = 1; k <= 900; k++) begin
         for (int d = 0; d < 3; d++) en[d] = ($urandom_range(0, 3) != 0);
         step();
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (tick[d] !== exp_tick(d) || spw[d] !== exp_spawn(d) || ry[d] !== exp_y(d)) begin
               errors++;
               $display("FAIL rand_en k=%0d d%0d: got tick=%b spawn=%b y=%0d want tick=%b spawn=%b y=%0d",
                        k, d, tick[d], spw[d], ry[d], exp_tick(d), exp_spawn(d), exp_y(d));
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      en    = 3'b000;
      seq[0] = 16'hACE1;
      for (int i = 1; i < 16384; i++)
         seq[i] = (seq[i-1] >> 1) ^ (seq[i-1][0] ? 16'hB400 : 16'h0000);

      test_reset();
      test_period90();
      test_rand_p3();
      test_pause();
      test_period1();
      test_reset_midcount();
      test_en_low();
      test_random_en();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
